rename_table: RTL and testbench
===============================

Name: rename_table

Overview:
- Front-end register alias table (RAT) for the 4-wide out-of-order core.
- Renames a group of up to WAYS decoded instructions per cycle: maps architectural sources to physical tags and allocates destination tags from the free list.
- Drives the free list's needed vector and consumes its reg_idx_out / reg_idx_out_valid.
- Registers renamed results for dispatch (ROB/RS); on exception, restores the whole map from the retirement RAT.

Parameters:
WAYS, 4, superscalar width
PRF, 64, physical register count
ARF, 32, architectural register count

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
except  in  1  mis-branch/exception flush
rrat_map  in  [ARF][log2 PRF]  retirement map, restore source
stall  in  1  dispatch cannot accept a group this cycle
valid_in  in  [WAYS]  decoded instruction present per way
rs1_idx, rs2_idx, rd_idx  in  [WAYS][log2 ARF]  architectural indices
rd_valid_in  in  [WAYS]  instruction writes rd
free_idx  in  [WAYS][log2 PRF]  free list reg_idx_out
free_valid  in  [WAYS]  free list reg_idx_out_valid
needed  out  [WAYS]  to free list
accepted  out  [WAYS]  ways renamed this cycle (combinational, to decode buffer)
out_valid  out  [WAYS]  registered renamed instruction valid
out_rs1_prf, out_rs2_prf  out  [WAYS][log2 PRF]  source tags
out_rd_prf  out  [WAYS][log2 PRF]  new destination tag
out_rd_old_prf  out  [WAYS][log2 PRF]  previous mapping of rd (ROB; later freed via RRAT)
out_rd_valid  out  [WAYS]  destination present

Behaviour:
- State: map[ARF] of log2(PRF) bits plus the output registers.
- Reset (async, reset==0): map[i]=i for all i; all out_* = 0. Matches the free list start-up state (PRF 0..31 busy).
- Per-way destination qualifier: dest[i] = valid_in[i] & rd_valid_in[i] & (rd_idx[i]!=0). x0 is never renamed; map[0] stays 0 forever.
- needed[i] = dest[i] & ~stall & ~except.
- Acceptance is in program order. k = lowest way with valid_in & dest & ~free_valid; if none, k = WAYS.
  - accepted[i] = valid_in[i] & (i<k) & ~stall & ~except.
  - accepted is a prefix mask of valid_in.
  - The free list grants validity in way order, so free_valid is a prefix over needed ways. No tag is granted to an unaccepted way.
- Sources for way i: newest accepted way j<i with dest[j] and rd_idx[j]==rsX_idx[i] supplies free_idx[j]; otherwise map[rsX_idx[i]]. rsX==0 always yields 0.
- out_rd_old_prf[i]: newest earlier in-group writer of the same rd if any, else map[rd_idx[i]].
- Map write on the same clock edge as acceptance:
  - map[rd_idx[i]] <= free_idx[i] for accepted dest ways.
  - In-group WAW: the highest way wins.
- Output registers, 1-cycle latency:
  - Normal: out_valid <= accepted; tag fields <= computed values; out_rd_valid <= dest & accepted. Fields for invalid ways are don't-care but deterministic (0).
  - Stall without except: all out_* hold; map unchanged; needed = 0; accepted = 0.
  - Except (dominates stall): map <= rrat_map wholesale; out_valid <= 0; out_rd_valid <= 0; no allocation this cycle.
- Reset asserted mid-operation clears immediately, independent of clock.

Test Plan:
- Reset release, single way: rs1=1, rs2=2, rd=3, free_idx[0]=32 -> needed=0001, accepted=0001; next cycle out_rs1=1, out_rs2=2, out_rd=32, out_rd_old=3; map[3]=32.
- Intra-group chain, all valid: way0 rd=5; way1 rs1=5, rd=5; way2 rs2=5; free tags 40,41 -> way1 rs1=40, rd_old=40; way2 rs2=41; map[5]=41.
- Free list short: 4 ways all with dest, free_valid=0011 -> accepted=0011; ways 2,3 remain for a later cycle; out_valid=0011.
- x0 handling: rd=0 on way0, rs1=0 on way1 -> needed[0]=0, out_rd_valid[0]=0, out_rs1[1]=0, map[0] unchanged.
- Stall and except: stall=1 -> accepted=0000, needed=0000, outputs hold. Then except=1 with rrat_map[7]=50 while stall=1 -> map[7]=50, out_valid=0000.
- Async reset pulse between clock edges -> outputs zero immediately; map identity on next read.

Source files
------------

// File: rtl/rename_table.sv
// rename_table: register alias table mapping architectural sources to physical tags and allocating destinations
module rename_table #(
   parameter  int WAYS = 4,
   parameter  int PRF  = 64,
   parameter  int ARF  = 32,
   localparam int PW   = $clog2(PRF),
   localparam int AW   = $clog2(ARF)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                except,
   input  logic [ARF*PW-1:0]   rrat_map,
   input  logic                stall,
   input  logic [WAYS-1:0]     valid_in,
   input  logic [WAYS*AW-1:0]  rs1_idx,
   input  logic [WAYS*AW-1:0]  rs2_idx,
   input  logic [WAYS*AW-1:0]  rd_idx,
   input  logic [WAYS-1:0]     rd_valid_in,
   input  logic [WAYS*PW-1:0]  free_idx,
   input  logic [WAYS-1:0]     free_valid,
   output logic [WAYS-1:0]     needed,
   output logic [WAYS-1:0]     accepted,
   output logic [WAYS-1:0]     out_valid,
   output logic [WAYS*PW-1:0]  out_rs1_prf,
   output logic [WAYS*PW-1:0]  out_rs2_prf,
   output logic [WAYS*PW-1:0]  out_rd_prf,
   output logic [WAYS*PW-1:0]  out_rd_old_prf,
   output logic [WAYS-1:0]     out_rd_valid
);
   logic [PW-1:0]      map [ARF];
   logic [WAYS-1:0]    wr;
   logic [WAYS*PW-1:0] n_rs1, n_rs2, n_rd, n_old;

   // in-order acceptance, free-list requests and bypassed source/old-dest lookup
   always_comb begin
      logic [WAYS-1:0] d, a;
      logic            blk;
      logic [AW-1:0]   r1, r2, rd, wj;
      logic [PW-1:0]   s1, s2, od, fj;
      d = '0;
      a = '0;
      blk = 1'b0;
      needed = '0;
      n_rs1 = '0;
      n_rs2 = '0;
      n_rd = '0;
      n_old = '0;
      for (int i = 0; i < WAYS; i++) begin
         r1 = rs1_idx[i*AW +: AW];
         r2 = rs2_idx[i*AW +: AW];
         rd = rd_idx[i*AW +: AW];
         d[i] = valid_in[i] & rd_valid_in[i] & (rd != '0);
         blk = blk | (d[i] & ~free_valid[i]);
         a[i] = valid_in[i] & ~blk & ~stall & ~except;
         needed[i] = d[i] & ~stall & ~except;
         s1 = map[r1];
         s2 = map[r2];
         od = map[rd];
         for (int j = 0; j < i; j++) begin
            wj = rd_idx[j*AW +: AW];
            fj = free_idx[j*PW +: PW];
            if (a[j] & d[j]) begin
               s1 = (wj == r1) ? fj : s1;
               s2 = (wj == r2) ? fj : s2;
               od = (wj == rd) ? fj : od;
            end
         end
         n_rs1[i*PW +: PW] = (a[i] && r1 != '0) ? s1 : '0;
         n_rs2[i*PW +: PW] = (a[i] && r2 != '0) ? s2 : '0;
         n_rd[i*PW +: PW]  = (a[i] & d[i]) ? free_idx[i*PW +: PW] : '0;
         n_old[i*PW +: PW] = (a[i] & d[i]) ? od : '0;
      end
      accepted = a;
      wr = a & d;
   end

   // speculative map: identity at reset, restored from retirement map on flush, highest way wins on WAW
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ARF; i++) map[i] <= PW'(i);
      end else if (except) begin
         for (int i = 0; i < ARF; i++) map[i] <= rrat_map[i*PW +: PW];
      end else begin
         for (int i = 0; i < WAYS; i++)
            if (wr[i]) map[rd_idx[i*AW +: AW]] <= free_idx[i*PW +: PW];
      end
   end

   // dispatch registers: hold on stall, invalidate on flush
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid      <= '0;
         out_rd_valid   <= '0;
         out_rs1_prf    <= '0;
         out_rs2_prf    <= '0;
         out_rd_prf     <= '0;
         out_rd_old_prf <= '0;
      end else if (except) begin
         out_valid    <= '0;
         out_rd_valid <= '0;
      end else if (!stall) begin
         out_valid      <= accepted;
         out_rd_valid   <= wr;
         out_rs1_prf    <= n_rs1;
         out_rs2_prf    <= n_rs2;
         out_rd_prf     <= n_rd;
         out_rd_old_prf <= n_old;
      end
   end
endmodule

// File: tb/tb_rename_table.sv
// tb_rename_table: directed checks of renaming, bypass, partial grant, x0, stall, flush and async reset
module tb_rename_table;
   logic         clock = 1'b0;
   logic         reset, except, stall;
   logic [191:0] rrat_map;
   logic [3:0]   valid_in, rd_valid_in, free_valid, needed, accepted, out_valid, out_rd_valid;
   logic [19:0]  rs1_idx, rs2_idx, rd_idx;
   logic [23:0]  free_idx, out_rs1_prf, out_rs2_prf, out_rd_prf, out_rd_old_prf;
   int           checks = 0, errors = 0;

   rename_table dut (
      .clock(clock), .reset(reset), .except(except), .rrat_map(rrat_map), .stall(stall),
      .valid_in(valid_in), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
      .rd_valid_in(rd_valid_in), .free_idx(free_idx), .free_valid(free_valid),
      .needed(needed), .accepted(accepted), .out_valid(out_valid),
      .out_rs1_prf(out_rs1_prf), .out_rs2_prf(out_rs2_prf), .out_rd_prf(out_rd_prf),
      .out_rd_old_prf(out_rd_old_prf), .out_rd_valid(out_rd_valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] sl(input logic [23:0] v, input int w);
      return v[w*6 +: 6];
   endfunction

   task automatic clr;
      valid_in = '0; rd_valid_in = '0; free_valid = '0;
      rs1_idx = '0; rs2_idx = '0; rd_idx = '0; free_idx = '0;
   endtask

   task automatic way(input int w, input int r1, input int r2, input int rd, input bit rdv,
                      input int fi, input bit fv);
      valid_in[w] = 1'b1;
      rs1_idx[w*5 +: 5] = 5'(r1);
      rs2_idx[w*5 +: 5] = 5'(r2);
      rd_idx[w*5 +: 5] = 5'(rd);
      rd_valid_in[w] = rdv;
      free_idx[w*6 +: 6] = 6'(fi);
      free_valid[w] = fv;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; except = 1'b0; stall = 1'b0;
      for (int i = 0; i < 32; i++) rrat_map[i*6 +: 6] = 6'(i);
      clr;
      #12;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_rd_prf", 32'(out_rd_prf), 0);
      check("rst_out_rd_valid", 32'(out_rd_valid), 0);
      reset = 1'b1;

      way(0, 1, 2, 3, 1, 32, 1);
      #1;
      check("t1_needed", 32'(needed), 4'b0001);
      check("t1_accepted", 32'(accepted), 4'b0001);
      tick;
      check("t1_out_valid", 32'(out_valid), 4'b0001);
      check("t1_rs1", 32'(sl(out_rs1_prf, 0)), 1);
      check("t1_rs2", 32'(sl(out_rs2_prf, 0)), 2);
      check("t1_rd", 32'(sl(out_rd_prf, 0)), 32);
      check("t1_rd_old", 32'(sl(out_rd_old_prf, 0)), 3);
      check("t1_rd_valid", 32'(out_rd_valid), 4'b0001);

      clr;
      way(0, 0, 0, 5, 1, 40, 1);
      way(1, 5, 0, 5, 1, 41, 1);
      way(2, 0, 5, 0, 0, 0, 0);
      way(3, 3, 0, 0, 0, 0, 0);
      #1;
      check("t2_needed", 32'(needed), 4'b0011);
      check("t2_accepted", 32'(accepted), 4'b1111);
      tick;
      check("t2_rd_old0", 32'(sl(out_rd_old_prf, 0)), 5);
      check("t2_rs1_w1", 32'(sl(out_rs1_prf, 1)), 40);
      check("t2_rd_old1", 32'(sl(out_rd_old_prf, 1)), 40);
      check("t2_rd_w1", 32'(sl(out_rd_prf, 1)), 41);
      check("t2_rs2_w2", 32'(sl(out_rs2_prf, 2)), 41);
      check("t2_map3", 32'(sl(out_rs1_prf, 3)), 32);
      check("t2_rd_valid", 32'(out_rd_valid), 4'b0011);

      clr;
      way(0, 5, 0, 6, 1, 42, 1);
      way(1, 6, 0, 7, 1, 43, 1);
      way(2, 0, 0, 8, 1, 44, 0);
      way(3, 0, 0, 9, 1, 45, 0);
      #1;
      check("t3_needed", 32'(needed), 4'b1111);
      check("t3_accepted", 32'(accepted), 4'b0011);
      tick;
      check("t3_out_valid", 32'(out_valid), 4'b0011);
      check("t3_map5", 32'(sl(out_rs1_prf, 0)), 41);
      check("t3_bypass", 32'(sl(out_rs1_prf, 1)), 42);
      check("t3_rd_w2", 32'(sl(out_rd_prf, 2)), 0);

      clr;
      way(0, 0, 0, 0, 1, 50, 0);
      way(1, 0, 7, 0, 0, 0, 0);
      #1;
      check("t4_needed", 32'(needed), 4'b0000);
      check("t4_accepted", 32'(accepted), 4'b0011);
      tick;
      check("t4_rd_valid", 32'(out_rd_valid), 4'b0000);
      check("t4_rs1_x0", 32'(sl(out_rs1_prf, 1)), 0);
      check("t4_map7", 32'(sl(out_rs2_prf, 1)), 43);

      clr;
      way(0, 6, 0, 10, 1, 51, 1);
      stall = 1'b1;
      #1;
      check("t5_stall_acc", 32'(accepted), 4'b0000);
      check("t5_stall_need", 32'(needed), 4'b0000);
      tick;
      check("t5_hold_valid", 32'(out_valid), 4'b0011);
      check("t5_hold_rs2", 32'(sl(out_rs2_prf, 1)), 43);
      except = 1'b1;
      rrat_map[7*6 +: 6] = 6'd50;
      #1;
      check("t5_exc_acc", 32'(accepted), 4'b0000);
      check("t5_exc_need", 32'(needed), 4'b0000);
      tick;
      check("t5_exc_valid", 32'(out_valid), 4'b0000);
      check("t5_exc_rd_valid", 32'(out_rd_valid), 4'b0000);
      except = 1'b0; stall = 1'b0;
      clr;
      way(0, 7, 6, 0, 0, 0, 0);
      way(1, 10, 0, 0, 0, 0, 0);
      tick;
      check("t5_restored7", 32'(sl(out_rs1_prf, 0)), 50);
      check("t5_restored6", 32'(sl(out_rs2_prf, 0)), 6);
      check("t5_no_write10", 32'(sl(out_rs1_prf, 1)), 10);
      check("t5_valid", 32'(out_valid), 4'b0011);

      #2 reset = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid), 0);
      check("t6_async_rs1", 32'(out_rs1_prf), 0);
      #1 reset = 1'b1;
      clr;
      way(0, 7, 5, 0, 0, 0, 0);
      tick;
      check("t6_out_valid", 32'(out_valid), 4'b0001);
      check("t6_id7", 32'(sl(out_rs1_prf, 0)), 7);
      check("t6_id5", 32'(sl(out_rs2_prf, 0)), 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
